// File: rtl/vid_pattern_gen.sv
// rtl/vid_pattern_gen.sv - video raster source with valid/ready beats and four test patterns
module vid_pattern_gen #(
  parameter int XResolution = 1920,
  parameter int YResolution = 1080,
  parameter int HFrontPorch = 88,
  parameter int HSyncWidth  = 44,
  parameter int HBackPorch  = 148,
  parameter int VFrontPorch = 4,
  parameter int VSyncWidth  = 5,
  parameter int VBackPorch  = 36
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       enable_i,
  input  logic [1:0] pattern_i,
  output logic [7:0] r_o,
  output logic [7:0] g_o,
  output logic [7:0] b_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       vde_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic [7:0] frame_cnt_o
);

  localparam int HTotal = XResolution + HFrontPorch + HSyncWidth + HBackPorch;
  localparam int VTotal = YResolution + VFrontPorch + VSyncWidth + VBackPorch;
  localparam int XW     = $clog2(HTotal);
  localparam int YW     = $clog2(VTotal);

  localparam int Bar1 = 1 * XResolution / 8;
  localparam int Bar2 = 2 * XResolution / 8;
  localparam int Bar3 = 3 * XResolution / 8;
  localparam int Bar4 = 4 * XResolution / 8;
  localparam int Bar5 = 5 * XResolution / 8;
  localparam int Bar6 = 6 * XResolution / 8;
  localparam int Bar7 = 7 * XResolution / 8;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    pat;

  logic [31:0] xi, yi;
  logic        first, last_x, last_y, load;
  logic [1:0]  cur_pat;
  logic        n_vde, n_hsync, n_vsync;
  logic [23:0] bar_rgb, n_rgb;

  assign xi     = 32'(x);
  assign yi     = 32'(y);
  assign first  = (x == '0) && (y == '0);
  assign last_x = (x == XW'(HTotal - 1));
  assign last_y = (y == YW'(VTotal - 1));
  assign load   = !valid_o || ready_i;

  // The (0,0) beat takes pattern_i directly so the new frame starts in the new pattern.
  assign cur_pat = first ? pattern_i : pat;

  always_comb begin
    n_vde   = (xi < XResolution) && (yi < YResolution);
    n_hsync = (xi >= XResolution + HFrontPorch) &&
              (xi <  XResolution + HFrontPorch + HSyncWidth);
    n_vsync = (yi >= YResolution + VFrontPorch) &&
              (yi <  YResolution + VFrontPorch + VSyncWidth);

    if      (xi < Bar1) bar_rgb = 24'hFFFFFF;
    else if (xi < Bar2) bar_rgb = 24'hFFFF00;
    else if (xi < Bar3) bar_rgb = 24'h00FFFF;
    else if (xi < Bar4) bar_rgb = 24'h00FF00;
    else if (xi < Bar5) bar_rgb = 24'hFF00FF;
    else if (xi < Bar6) bar_rgb = 24'hFF0000;
    else if (xi < Bar7) bar_rgb = 24'h0000FF;
    else                bar_rgb = 24'h000000;

    case (cur_pat)
      2'd0:    n_rgb = bar_rgb;
      2'd1:    n_rgb = {xi[7:0], yi[7:0], frame_cnt_o};
      2'd2:    n_rgb = (xi[4] ^ yi[4]) ? 24'hFFFFFF : 24'h000000;
      default: n_rgb = {frame_cnt_o, frame_cnt_o, frame_cnt_o};
    endcase

    if (!n_vde) n_rgb = 24'h000000;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x           <= '0;
      y           <= '0;
      pat         <= 2'd0;
      r_o         <= 8'd0;
      g_o         <= 8'd0;
      b_o         <= 8'd0;
      hsync_o     <= 1'b0;
      vsync_o     <= 1'b0;
      vde_o       <= 1'b0;
      valid_o     <= 1'b0;
      frame_cnt_o <= 8'd0;
    end else if (load) begin
      if (enable_i) begin
        {r_o, g_o, b_o} <= n_rgb;
        hsync_o         <= n_hsync;
        vsync_o         <= n_vsync;
        vde_o           <= n_vde;
        valid_o         <= 1'b1;
        if (first) pat <= pattern_i;
        if (last_x) begin
          x <= '0;
          if (last_y) begin
            y           <= '0;
            frame_cnt_o <= frame_cnt_o + 8'd1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end else begin
        // Only reached once the pending beat is taken, so no beat is ever withdrawn.
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// tb/tb_vid_pattern_gen.sv - directed self-checking bench for vid_pattern_gen on a 22x7 raster
module tb_vid_pattern_gen;

  localparam int XRes = 16, YRes = 4, HFP = 2, HSW = 2, HBP = 2;
  localparam int VFP = 1, VSW = 1, VBP = 1;
  localparam int HTot = 22, VTot = 7;

  logic       clk = 1'b0;
  logic       rst, enable, ready;
  logic [1:0] pattern;
  logic [7:0] r, g, b, frame_cnt;
  logic       hsync, vsync, vde, valid;

  int checks = 0;
  int errors = 0;

  int nx, ny, nf;
  int bx, by, bf;
  int mpat, bpat;
  int vs_cnt, hs_cnt;

  vid_pattern_gen #(
    .XResolution(XRes), .YResolution(YRes),
    .HFrontPorch(HFP), .HSyncWidth(HSW), .HBackPorch(HBP),
    .VFrontPorch(VFP), .VSyncWidth(VSW), .VBackPorch(VBP)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .pattern_i(pattern),
    .r_o(r), .g_o(g), .b_o(b), .hsync_o(hsync), .vsync_o(vsync), .vde_o(vde),
    .valid_o(valid), .ready_i(ready), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] bar_of(input int xx);
    case (xx / 2)
      0:       return 24'hFFFFFF;
      1:       return 24'hFFFF00;
      2:       return 24'h00FFFF;
      3:       return 24'h00FF00;
      4:       return 24'hFF00FF;
      5:       return 24'hFF0000;
      6:       return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [23:0] exp_rgb();
    if (!(bx < XRes && by < YRes)) return 24'h0;
    case (bpat)
      0:       return bar_of(bx);
      1:       return {8'(bx), 8'(by), 8'(bf)};
      2:       return (((bx >> 4) ^ (by >> 4)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
      default: return {8'(bf), 8'(bf), 8'(bf)};
    endcase
  endfunction

  // Advance the reference raster after an edge that produced a new beat.
  task automatic model_gen();
    bpat = (nx == 0 && ny == 0) ? int'(pattern) : mpat;
    mpat = bpat;
    bx = nx; by = ny; bf = nf;
    if (nx == HTot - 1) begin
      nx = 0;
      if (ny == VTot - 1) begin ny = 0; nf = (nf + 1) % 256; end
      else ny++;
    end else nx++;
  endtask

  task automatic beat();
    step();
    model_gen();
    chk("valid", 32'(valid), 32'd1);
    chk("vde", 32'(vde), 32'(bx < XRes && by < YRes));
    chk("hsync", 32'(hsync), 32'(bx == 18 || bx == 19));
    chk("vsync", 32'(vsync), 32'(by == 5));
    chk("rgb", {8'd0, r, g, b}, {8'd0, exp_rgb()});
    chk("frame_cnt", 32'(frame_cnt), 32'(nf));
    if (vsync) vs_cnt++;
    if (hsync) hs_cnt++;
  endtask

  task automatic model_reset();
    nx = 0; ny = 0; nf = 0; mpat = 0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; ready = 1'b1; pattern = 2'd0;
    model_reset();
    step(); step();
    chk("reset_outputs", {r, g, b, hsync, vsync, vde, valid}, 32'h0);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    enable = 1'b1;

    // Frame 0: bars; pattern changes to checker mid-frame without tearing
    vs_cnt = 0; hs_cnt = 0;
    for (int n = 0; n < 154; n++) begin
      if (n == 40) pattern = 2'd2;
      beat();
      if (n == 0) begin
        chk("first_white", {8'd0, r, g, b}, 32'hFFFFFF);
        chk("first_vde", 32'(vde), 32'd1);
      end
      if (n == 2)   chk("x2_yellow", {8'd0, r, g, b}, 32'hFFFF00);
      if (n == 15)  chk("x15_black", {8'd0, r, g, b}, 32'h000000);
      if (n == 50)  chk("no_tear_green", {8'd0, r, g, b}, 32'h00FF00);
      if (n == 152) chk("frame_cnt_before", 32'(frame_cnt), 32'd0);
    end
    chk("frame_cnt_154", 32'(frame_cnt), 32'd1);
    chk("vsync_beats", 32'(vs_cnt), 32'd22);
    chk("hsync_beats", 32'(hs_cnt), 32'd14);

    // Frame 1: checker
    for (int n = 0; n < 154; n++) begin
      if (n == 100) pattern = 2'd1;
      beat();
      if (n == 0) chk("chk_00_black", {8'd0, r, g, b}, 32'h0);
      if (n == 16) begin
        chk("chk_16_blank_vde", 32'(vde), 32'd0);
        chk("chk_16_blank_rgb", {8'd0, r, g, b}, 32'h0);
      end
      if (n == 27) chk("chk_5_1_black", {8'd0, r, g, b}, 32'h0);
    end

    // Frame 2: gradient with backpressure at (3,1)
    for (int n = 0; n < 26; n++) beat();
    chk("grad_3_1", {8'd0, r, g, b}, 32'h030102);
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", 32'(valid), 32'd1);
      chk("bp_rgb", {8'd0, r, g, b}, 32'h030102);
      chk("bp_sync", {29'd0, hsync, vsync, vde}, 32'd1);
    end
    ready = 1'b1;
    beat();
    chk("bp_resume_4_1", {8'd0, r, g, b}, 32'h040102);
    for (int n = 27; n < 53; n++) beat();
    chk("grad_8_2", {8'd0, r, g, b}, 32'h080202);

    // Enable drop while stalled
    ready = 1'b0; enable = 1'b0;
    step();
    chk("drop_hold1", 32'(valid), 32'd1);
    step();
    chk("drop_hold2", 32'(valid), 32'd1);
    chk("drop_hold_rgb", {8'd0, r, g, b}, 32'h080202);
    ready = 1'b1;
    step();
    chk("drop_accept", 32'(valid), 32'd0);
    step();
    chk("drop_idle", 32'(valid), 32'd0);
    enable = 1'b1;
    beat();
    chk("reenable_9_2", {8'd0, r, g, b}, 32'h090202);
    for (int n = 54; n < 72; n++) beat();
    chk("grad_5_3", {8'd0, r, g, b}, 32'h050302);

    // Rest of frame 2, then frame 3 (bars) up to (7,2) and reset there
    pattern = 2'd0;
    for (int n = 72; n < 154; n++) beat();
    for (int n = 0; n < 52; n++) beat();
    chk("pre_reset_green", {8'd0, r, g, b}, 32'h00FF00);
    chk("pre_reset_cnt", 32'(frame_cnt), 32'd3);
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {r, g, b, hsync, vsync, vde, valid}, 32'h0);
    chk("async_rst_cnt", 32'(frame_cnt), 32'd0);
    pattern = 2'd3;
    step();
    rst = 1'b0;
    model_reset();

    // Three flat frames after reset
    for (int n = 0; n < 462; n++) begin
      beat();
      if (n == 0) begin
        chk("post_rst_cnt", 32'(frame_cnt), 32'd0);
        chk("post_rst_vde", 32'(vde), 32'd1);
      end
      if (n == 154 + 3)       chk("flat_f1", {8'd0, r, g, b}, 32'h010101);
      if (n == 308 + 22 + 3)  chk("flat_f2", {8'd0, r, g, b}, 32'h020202);
      if (n == 308 + 16)      chk("flat_blank", {8'd0, r, g, b}, 32'h0);
    end
    chk("flat_end_cnt", 32'(frame_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vid_pattern_gen.md
Name: vid_pattern_gen

Overview:
- Source end of the pixel-stream interface consumed by the RGB processing pipeline.
- Generates a complete video raster with valid/ready handshake: r/g/b, hsync, vsync and vde, including blanking intervals.
- Sits in place of the HDMI receiver path for bring-up and for self-test of the filter chain.
- Emits one of four selectable test patterns and a free-running frame counter.

Parameters:
XResolution, 1920, active pixels per line
YResolution, 1080, active lines per frame
HFrontPorch, 88, blank pixels between active end and hsync
HSyncWidth, 44, hsync pulse width in pixels
HBackPorch, 148, blank pixels after hsync
VFrontPorch, 4, blank lines between active end and vsync
VSyncWidth, 5, vsync pulse width in lines
VBackPorch, 36, blank lines after vsync

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
enable_i  in  1  allow generation of new beats
pattern_i  in  2  pattern select: 0 bars, 1 gradient, 2 checker, 3 flat
r_o  out  8  red
g_o  out  8  green
b_o  out  8  blue
hsync_o  out  1  horizontal sync, active-high
vsync_o  out  1  vertical sync, active-high
vde_o  out  1  active video
valid_o  out  1  beat valid
ready_i  in  1  downstream ready
frame_cnt_o  out  8  completed-frame counter

Behaviour:
- HTotal = XResolution+HFrontPorch+HSyncWidth+HBackPorch. VTotal is the same sum over the vertical parameters.
- Counters x in [0,HTotal-1] and y in [0,VTotal-1]. Widths are $clog2 of the totals.
- Reset: all outputs 0, x=y=0, frame_cnt_o=0, latched pattern=0.
- Load condition: load = !valid_o || ready_i. All outputs are registered and stay stable while valid_o && !ready_i.
- On load with enable_i=1:
  - Register the beat for the current (x,y) and set valid_o to 1.
  - Advance x. At x=HTotal-1, wrap x to 0 and advance y.
  - At x=HTotal-1 and y=VTotal-1, wrap y to 0 and increment frame_cnt_o (mod 256).
- On load with enable_i=0: valid_o goes to 0 and the counters hold.
- valid_o never drops without a handshake, so enable_i=0 takes effect only after the pending beat is accepted.
- Latency: first beat (0,0) is valid on the first clock edge after reset release where enable_i=1.
- Beat fields:
  - vde = (x<XResolution) && (y<YResolution).
  - hsync = (x >= XResolution+HFrontPorch) && (x < XResolution+HFrontPorch+HSyncWidth).
  - vsync = (y >= YResolution+VFrontPorch) && (y < YResolution+VFrontPorch+VSyncWidth). vsync is asserted for entire lines, including their blanking pixels.
  - r/g/b = 0 whenever vde=0.
- Pattern latch: pattern_i is sampled only when the beat for (0,0) is loaded. That value applies to the whole frame (no tearing).
- Pattern 0, colour bars:
  - 8 bars. Bar k spans k*XResolution/8 to (k+1)*XResolution/8-1, with the bounds as integer localparams.
  - Bar order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
- Pattern 1, gradient: r=x[7:0], g=y[7:0], b=frame_cnt[7:0].
- Pattern 2, checker: (x[4]^y[4]) ? FFFFFF : 000000.
- Pattern 3, flat: r=g=b=frame_cnt[7:0].
  - frame_cnt here is the value at the time the beat is loaded.
  - frame_cnt_o updates on the same edge that loads beat (HTotal-1,VTotal-1).
- Reset asserted mid-frame immediately clears all state. Generation restarts at (0,0) with no partial frame resumption.
- Simultaneous ready_i=1 and enable_i falling: the current beat is accepted and valid_o goes to 0 on the same edge.

Test Plan:
- Common bench parameters: XRes=16, YRes=4, HFP=2, HSW=2, HBP=2 (HTotal=22); VFP=1, VSW=1, VBP=1 (VTotal=7).
- Reset release, enable_i=1, ready_i=1, pattern 0:
  - First beat is (0,0) with FFFFFF and vde=1.
  - x=2 gives FFFF00; x=15 gives 000000.
  - hsync_o=1 exactly at x=18,19 on every line.
  - vsync_o=1 for all 22 beats of y=5.
  - frame_cnt_o=1 after 154 accepted beats.
- Backpressure: hold ready_i=0 for 5 cycles mid-line.
  - valid_o stays 1 and r/g/b/sync stay constant.
  - On release, beats continue with no skip or duplicate (sequence check on x,y).
- Drop enable_i while valid_o=1 and ready_i=0:
  - valid_o stays 1 until a ready_i=1 cycle, then goes 0.
  - Re-enable resumes at the next (x,y).
- Change pattern_i from 0 to 2 mid-frame:
  - Frame stays bars.
  - Next frame beat (0,0) is 000000 and beat (16,0) is not visible (blank); checker visible at y≥... with x[4]=0 giving black for x<16.
  - Check gradient mode separately: beat (5,3) gives r=05, g=03.
- Pattern 3 over 3 frames: all active pixels of frame n carry r=g=b=n (n=0,1,2); blanking is 0.
- Assert rst_i at (7,2): all outputs go to 0 asynchronously; after release the first beat is (0,0) and frame_cnt_o=0.
